// File: rtl/kbd_filter.sv
// ---------------------------------------------------------------------------
// kbd_filter
//
// Receive-side stage between the FT245 FIFO read path and the 6821 PIA
// keyboard port (port A plus the CA1 strobe). Raw host bytes arrive over a
// valid/ready handshake. Each byte is translated to Apple-1 keyboard
// conventions as it is accepted, and the result is stored in a small FIFO.
// Characters then go to the PIA one at a time: PA is loaded, held stable for
// one cycle, strobed on CA1 for STROBE_CYCLES cycles, and the block then
// waits for the CPU to read port A.
//
// Parameters:
//   DEPTH          character buffer entries (power of two, >= 2)
//   STROBE_CYCLES  CA1 high time in clk cycles (1..255)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   raw byte available from the FIFO read path
//   in_data    in   raw host byte [7:0]
//   in_ready   out  block can accept a byte this cycle (combinational)
//   pia_rd     in   one-cycle pulse: CPU read PIA port A
//   pia_pa     out  character to PIA port A [6:0] (registered)
//   pia_ca1    out  keyboard strobe, active high (registered)
//   overflow   out  sticky: host held in_valid against a stalled input for
//                   more than 1024 consecutive cycles; cleared only by reset
//
// Build option:
//   KBD_UPCASE_EN  when defined, lowercase a..z is folded to uppercase
//                  (the standard Apple-1 build, whose monitor only accepts
//                  uppercase). When undefined the fold logic is not built.
// ---------------------------------------------------------------------------

module kbd_filter #(
    parameter int DEPTH         = 4,
    parameter int STROBE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       pia_rd,
    output logic [6:0] pia_pa,
    output logic       pia_ca1,
    output logic       overflow
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [7:0]  STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [10:0] STALL_LIMIT = 11'd1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT
    } state_t;

    // -----------------------------------------------------------------------
    // Character buffer
    // -----------------------------------------------------------------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate count.
    logic [6:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // No bypass: a pop in the same cycle never frees a slot for a push when
    // the buffer is full.
    assign in_ready = !full && !reset;

    // -----------------------------------------------------------------------
    // Translation (applied at accept time)
    // -----------------------------------------------------------------------
    logic [6:0] in_char;
    logic [6:0] xl_char;
    logic       xl_drop;
    logic       cr_seen;
    logic       accept;
    logic       push;
    logic       pop;

    // Bit 7 is always cleared, so the MSB of the raw byte never matters.
    logic unused_in_msb;
    assign unused_in_msb = in_data[7];

    assign in_char = in_data[6:0];

    // NOTE: every output of a combinational block gets a default on entry;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        xl_char = in_char;
        xl_drop = 1'b0;
        case (in_char)
            7'h0D: xl_char = 7'h0D;
            7'h0A: begin
                // LF straight after CR collapses into the CR already stored;
                // a lone LF becomes CR, the Apple-1 line terminator.
                xl_char = 7'h0D;
                xl_drop = cr_seen;
            end
            7'h7F: xl_char = 7'h5F;  // Apple-1 rubout is the underscore
            7'h00: xl_drop = 1'b1;
            default: begin
`ifdef KBD_UPCASE_EN
                if (in_char >= 7'h61 && in_char <= 7'h7A) begin
                    xl_char = in_char - 7'h20;
                end
`endif
            end
        endcase
    end

    assign accept = in_valid && in_ready;
    // A dropped byte still completes the handshake but is never written.
    assign push   = accept && !xl_drop;

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers alone, so clearing them is enough and the array can map onto
    // plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= xl_char;
        end
    end

    // NOTE: clocked state is always updated with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cr_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            // Only a CR arms the LF collapse; any other accepted byte,
            // including a dropped one, disarms it.
            if (accept) begin
                cr_seen <= (in_char == 7'h0D);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stall watchdog: counts consecutive cycles the host offers a byte while
    // the input is stalled. The flag is a debug aid and is sticky.
    // -----------------------------------------------------------------------
    logic [10:0] stall_cnt;
    logic        stalled;

    assign stalled = in_valid && !in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            overflow  <= 1'b0;
        end else if (stalled) begin
            // stall_cnt holds the number of earlier stalled cycles in this
            // run; reaching the limit here means this is cycle 1025.
            if (stall_cnt == STALL_LIMIT) begin
                overflow <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 11'd1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Output FSM: PA load, one setup cycle, CA1 strobe, wait for CPU read.
    // -----------------------------------------------------------------------
    state_t     state;
    logic [7:0] strobe_cnt;
    logic       rd_latched;

    assign pop = (state == ST_IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pia_pa     <= '0;
            pia_ca1    <= 1'b0;
            strobe_cnt <= '0;
            rd_latched <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        pia_pa     <= mem[rd_ptr[AW-1:0]];
                        rd_latched <= 1'b0;
                        state      <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // PA has been stable for one cycle; start the strobe.
                    pia_ca1    <= 1'b1;
                    strobe_cnt <= STROBE_LAST;
                    state      <= ST_STROBE;
                    if (pia_rd) begin
                        rd_latched <= 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (strobe_cnt == 8'd0) begin
                        pia_ca1    <= 1'b0;
                        rd_latched <= 1'b0;
                        // A read that already arrived during the strobe means
                        // the CPU has the character; skip the wait.
                        if (rd_latched || pia_rd) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt - 8'd1;
                        if (pia_rd) begin
                            rd_latched <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (pia_rd) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
